// File: rtl/seg7_scan_ctrl_if.sv
// Store-only bus from the bus bridge into the 7-seg window.
// The master drives word stores, and the display controller is the slave.
interface seg7_scan_ctrl_if;
  logic [11:0] addr;
  logic        we;
  logic [31:0] wdata;

  modport master (output addr, output we, output wdata);
  modport slave  (input  addr, input  we, input  wdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed seven-segment display controller.
// It holds a DATA register (eight hex nibbles) and a CTRL register
// (digit-enable mask and decimal-point mask). It scans one digit per slot,
// with a blank window at the start of each slot to suppress ghosting.
// Every output, including the active-low segments and enables, comes
// straight from a flop.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 16
) (
  input  logic           cpu_clk,
  input  logic           cpu_rst_n,
  seg7_scan_ctrl_if.slave bus,
  output logic [7:0]     dig_en,
  output logic           DN_A,
  output logic           DN_B,
  output logic           DN_C,
  output logic           DN_D,
  output logic           DN_E,
  output logic           DN_F,
  output logic           DN_G,
  output logic           DN_DP
);

  localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  // Hex digit to active-low segments, packed as {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    idx_q,    idx_d;
  logic [31:0]   data_q,   data_d;
  logic [15:0]   ctrl_q,   ctrl_d;
  logic [7:0]    dig_en_q, dig_en_d;
  logic [6:0]    seg_q,    seg_d;
  logic          dp_q,     dp_d;

  logic          sel_ok_s;
  logic          blank_s;
  logic [3:0]    nib_s;

  // Address bits below word granularity and the reserved CTRL bits are never
  // stored. This reduction only keeps them visibly consumed.
  logic unused_bits_s;
  assign unused_bits_s = ^{bus.addr[1:0], bus.wdata[31:16]};

  // Next-state for registers, scan position and the display outputs, all from
  // pre-edge state. A masked digit is treated like the blank window.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    dig_en_d = 8'hFF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;

    sel_ok_s = (bus.addr[11:3] == 9'd0);
    if (bus.we && sel_ok_s) begin
      if (bus.addr[2]) begin
        ctrl_d = bus.wdata[15:0];
      end else begin
        data_d = bus.wdata;
      end
    end else begin
      data_d = data_q;
    end

    if (cnt_q == CNT_LAST) begin
      cnt_d = {CW{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    nib_s   = data_q[{idx_q, 2'b00} +: 4];
    blank_s = (cnt_q < BLANK_END) || !ctrl_q[{1'b0, idx_q}];
    if (blank_s) begin
      dig_en_d = 8'hFF;
      seg_d    = 7'h7F;
      dp_d     = 1'b1;
    end else begin
      dig_en_d = ~(8'h01 << idx_q);
      seg_d    = hex_to_seg(nib_s);
      dp_d     = ~ctrl_q[{1'b1, idx_q}];
    end
  end

  // State and output flops. Reset forces the display dark at once.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cnt_q    <= {CW{1'b0}};
      idx_q    <= 3'd0;
      data_q   <= 32'h0000_0000;
      ctrl_q   <= 16'h00FF;
      dig_en_q <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign dig_en = dig_en_q;
  assign DN_A   = seg_q[0];
  assign DN_B   = seg_q[1];
  assign DN_C   = seg_q[2];
  assign DN_D   = seg_q[3];
  assign DN_E   = seg_q[4];
  assign DN_F   = seg_q[5];
  assign DN_G   = seg_q[6];
  assign DN_DP  = dp_q;

endmodule
